// File: rtl/commit_tracker.sv
// Commit tracker: circular buffer of in-flight instruction entries.
// Up to two entries are allocated at the tail and up to two retire in order from the head.
// Each entry moves FREE -> ALLOC -> ISSUED -> DONE -> FREE.
// A completion that carries a fault blocks the head until a flush.
module commit_tracker #(
  parameter int unsigned NCOMMIT  = 32,
  parameter int unsigned LNCOMMIT = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          alloc_count,
  output logic [1:0]          alloc_avail,
  output logic [LNCOMMIT-1:0] tail,
  input  logic                issue_enable_0,
  input  logic [LNCOMMIT-1:0] issue_addr_0,
  input  logic                issue_enable_1,
  input  logic [LNCOMMIT-1:0] issue_addr_1,
  input  logic                done_enable_0,
  input  logic [LNCOMMIT-1:0] done_addr_0,
  input  logic                done_fault_0,
  input  logic                done_enable_1,
  input  logic [LNCOMMIT-1:0] done_addr_1,
  input  logic                done_fault_1,
  input  logic                flush,
  output logic [NCOMMIT-1:0]  pending,
  output logic [LNCOMMIT-1:0] head,
  output logic [1:0]          retire_count,
  output logic                fault_valid,
  output logic [LNCOMMIT-1:0] fault_addr,
  output logic [LNCOMMIT:0]   count,
  output logic                empty,
  output logic                full
);

  typedef logic [LNCOMMIT-1:0] idx_t;
  typedef logic [LNCOMMIT:0]   cnt_t;

  localparam cnt_t NcommitCnt = cnt_t'(NCOMMIT);

  // Per-entry state bits
  logic [NCOMMIT-1:0] alloc_q, alloc_d;
  logic [NCOMMIT-1:0] issued_q, issued_d;
  logic [NCOMMIT-1:0] done_q, done_d;
  logic [NCOMMIT-1:0] fault_q, fault_d;

  // Pointers and occupancy
  idx_t head_q, head_d;
  idx_t tail_q, tail_d;
  cnt_t count_q, count_d;

  // Derived values
  cnt_t       free_cnt;
  idx_t       head_p1;
  idx_t       tail_p1;
  logic       ret0;
  logic       ret1;
  logic       alloc_ok;
  logic [1:0] alloc_acc;

  assign free_cnt = NcommitCnt - count_q;
  assign head_p1  = head_q + idx_t'(1);
  assign tail_p1  = tail_q + idx_t'(1);

  // Free-slot advertisement is based on registered count only
  always_comb begin
    alloc_avail = 2'd2;
    if (free_cnt < cnt_t'(2)) begin
      alloc_avail = free_cnt[1:0];
    end
  end

  // An oversized request is dropped as a whole, never partially honoured
  always_comb begin
    alloc_ok  = (alloc_count <= alloc_avail);
    alloc_acc = 2'd0;
    if (alloc_ok && !flush) begin
      alloc_acc = alloc_count;
    end
  end

  // In-order retirement from registered state; a faulting head blocks everything behind it
  always_comb begin
    ret0         = alloc_q[head_q] & done_q[head_q] & ~fault_q[head_q];
    ret1         = alloc_q[head_p1] & done_q[head_p1] & ~fault_q[head_p1];
    retire_count = 2'd0;
    if (!flush && ret0) begin
      retire_count = ret1 ? 2'd2 : 2'd1;
    end
  end

  // Next-state for entries, pointers and count
  always_comb begin
    alloc_d  = alloc_q;
    issued_d = issued_q;
    done_d   = done_q;
    fault_d  = fault_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;

    // Issue only moves ALLOC -> ISSUED; both ports on one entry collapse naturally
    if (issue_enable_0 && alloc_q[issue_addr_0] && !issued_q[issue_addr_0]) begin
      issued_d[issue_addr_0] = 1'b1;
    end
    if (issue_enable_1 && alloc_q[issue_addr_1] && !issued_q[issue_addr_1]) begin
      issued_d[issue_addr_1] = 1'b1;
    end

    // Completion checks the registered issued bit, so a same-cycle issue+done is dropped
    if (done_enable_0 && alloc_q[done_addr_0] && issued_q[done_addr_0]) begin
      done_d[done_addr_0]  = 1'b1;
      fault_d[done_addr_0] = fault_d[done_addr_0] | done_fault_0;
    end
    if (done_enable_1 && alloc_q[done_addr_1] && issued_q[done_addr_1]) begin
      done_d[done_addr_1]  = 1'b1;
      fault_d[done_addr_1] = fault_d[done_addr_1] | done_fault_1;
    end

    // Retiring entries return to FREE
    if (retire_count != 2'd0) begin
      alloc_d[head_q]  = 1'b0;
      issued_d[head_q] = 1'b0;
      done_d[head_q]   = 1'b0;
      fault_d[head_q]  = 1'b0;
    end
    if (retire_count == 2'd2) begin
      alloc_d[head_p1]  = 1'b0;
      issued_d[head_p1] = 1'b0;
      done_d[head_p1]   = 1'b0;
      fault_d[head_p1]  = 1'b0;
    end

    // Allocation targets free slots at the tail, so it never collides with the above
    if (alloc_acc != 2'd0) begin
      alloc_d[tail_q]  = 1'b1;
      issued_d[tail_q] = 1'b0;
      done_d[tail_q]   = 1'b0;
      fault_d[tail_q]  = 1'b0;
    end
    if (alloc_acc == 2'd2) begin
      alloc_d[tail_p1]  = 1'b1;
      issued_d[tail_p1] = 1'b0;
      done_d[tail_p1]   = 1'b0;
      fault_d[tail_p1]  = 1'b0;
    end

    head_d  = head_q + idx_t'(retire_count);
    tail_d  = tail_q + idx_t'(alloc_acc);
    count_d = count_q + cnt_t'(alloc_acc) - cnt_t'(retire_count);

    // Flush discards everything regardless of other activity
    if (flush) begin
      alloc_d  = '0;
      issued_d = '0;
      done_d   = '0;
      fault_d  = '0;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      alloc_q  <= '0;
      issued_q <= '0;
      done_q   <= '0;
      fault_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      alloc_q  <= alloc_d;
      issued_q <= issued_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  // Flag allocation requests that exceed the advertised free slots
  always_ff @(posedge clk) begin
    if (reset && !flush) begin
      assert (alloc_ok)
        else $warning("commit_tracker: alloc_count %0d exceeds alloc_avail %0d, request dropped",
                      alloc_count, alloc_avail);
    end
  end

  // Output mapping
  assign pending     = alloc_q & ~issued_q;
  assign head        = head_q;
  assign tail        = tail_q;
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == NcommitCnt);
  assign fault_valid = alloc_q[head_q] & done_q[head_q] & fault_q[head_q];
  assign fault_addr  = head_q;

endmodule

// File: tb/tb_commit_tracker.sv
// Directed testbench for commit_tracker.
module tb_commit_tracker;

  localparam int unsigned NCOMMIT  = 32;
  localparam int unsigned LNCOMMIT = 5;

  logic                clk;
  logic                reset;
  logic [1:0]          alloc_count;
  logic [1:0]          alloc_avail;
  logic [LNCOMMIT-1:0] tail;
  logic                issue_enable_0, issue_enable_1;
  logic [LNCOMMIT-1:0] issue_addr_0, issue_addr_1;
  logic                done_enable_0, done_enable_1;
  logic [LNCOMMIT-1:0] done_addr_0, done_addr_1;
  logic                done_fault_0, done_fault_1;
  logic                flush;
  logic [NCOMMIT-1:0]  pending;
  logic [LNCOMMIT-1:0] head;
  logic [1:0]          retire_count;
  logic                fault_valid;
  logic [LNCOMMIT-1:0] fault_addr;
  logic [LNCOMMIT:0]   count;
  logic                empty;
  logic                full;

  int tests_run    = 0;
  int tests_failed = 0;

  commit_tracker #(
    .NCOMMIT (NCOMMIT),
    .LNCOMMIT(LNCOMMIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .alloc_count   (alloc_count),
    .alloc_avail   (alloc_avail),
    .tail          (tail),
    .issue_enable_0(issue_enable_0),
    .issue_addr_0  (issue_addr_0),
    .issue_enable_1(issue_enable_1),
    .issue_addr_1  (issue_addr_1),
    .done_enable_0 (done_enable_0),
    .done_addr_0   (done_addr_0),
    .done_fault_0  (done_fault_0),
    .done_enable_1 (done_enable_1),
    .done_addr_1   (done_addr_1),
    .done_fault_1  (done_fault_1),
    .flush         (flush),
    .pending       (pending),
    .head          (head),
    .retire_count  (retire_count),
    .fault_valid   (fault_valid),
    .fault_addr    (fault_addr),
    .count         (count),
    .empty         (empty),
    .full          (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    reset          = 1'b1;
    alloc_count    = 2'd0;
    issue_enable_0 = 1'b0;
    issue_addr_0   = '0;
    issue_enable_1 = 1'b0;
    issue_addr_1   = '0;
    done_enable_0  = 1'b0;
    done_addr_0    = '0;
    done_fault_0   = 1'b0;
    done_enable_1  = 1'b0;
    done_addr_1    = '0;
    done_fault_1   = 1'b0;
    flush          = 1'b0;
  endtask

  // Apply the currently driven inputs for one edge, then return inputs to idle
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_alloc(input logic [1:0] n);
    alloc_count = n;
    step();
  endtask

  task automatic do_issue(input logic e0, input logic [4:0] a0, input logic e1,
                          input logic [4:0] a1);
    issue_enable_0 = e0; issue_addr_0 = a0;
    issue_enable_1 = e1; issue_addr_1 = a1;
    step();
  endtask

  task automatic do_done(input logic e0, input logic [4:0] a0, input logic f0,
                         input logic e1, input logic [4:0] a1, input logic f1);
    done_enable_0 = e0; done_addr_0 = a0; done_fault_0 = f0;
    done_enable_1 = e1; done_addr_1 = a1; done_fault_1 = f1;
    step();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests_run++; if (pending !== 32'h0) begin tests_failed++;
      $display("FAIL reset_pending: got %h want %h", pending, 32'h0); end
    tests_run++; if (retire_count !== 2'd0) begin tests_failed++;
      $display("FAIL reset_retire: got %0d want 0", retire_count); end
    tests_run++; if (fault_valid !== 1'b0) begin tests_failed++;
      $display("FAIL reset_fault_valid: got %b want 0", fault_valid); end
    tests_run++; if (empty !== 1'b1 || full !== 1'b0) begin tests_failed++;
      $display("FAIL reset_empty_full: got %b/%b want 1/0", empty, full); end
    tests_run++; if (alloc_avail !== 2'd2) begin tests_failed++;
      $display("FAIL reset_alloc_avail: got %0d want 2", alloc_avail); end
    tests_run++; if (head !== 5'd0 || tail !== 5'd0 || count !== 6'd0) begin tests_failed++;
      $display("FAIL reset_ptrs: got h%0d t%0d c%0d want 0/0/0", head, tail, count); end
    idle();
  endtask

  task automatic test_alloc_issue();
    do_alloc(2'd2);
    tests_run++; if (tail !== 5'd2 || count !== 6'd2) begin tests_failed++;
      $display("FAIL alloc2_ptrs: got t%0d c%0d want t2 c2", tail, count); end
    tests_run++; if (pending !== 32'h3) begin tests_failed++;
      $display("FAIL alloc2_pending: got %h want %h", pending, 32'h3); end
    do_issue(1'b1, 5'd0, 1'b0, 5'd0);
    tests_run++; if (pending !== 32'h2) begin tests_failed++;
      $display("FAIL issue0_pending: got %h want %h", pending, 32'h2); end
    // Both ports on entry 1 act as a single issue
    do_issue(1'b1, 5'd1, 1'b1, 5'd1);
    tests_run++; if (pending !== 32'h0 || count !== 6'd2) begin tests_failed++;
      $display("FAIL dual_issue: got p%h c%0d want p0 c2", pending, count); end
  endtask

  task automatic test_out_of_order();
    do_done(1'b1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0);
    tests_run++; if (retire_count !== 2'd0 || head !== 5'd0) begin tests_failed++;
      $display("FAIL ooo_first: got r%0d h%0d want r0 h0", retire_count, head); end
    do_done(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    tests_run++; if (retire_count !== 2'd2) begin tests_failed++;
      $display("FAIL ooo_retire2: got %0d want 2", retire_count); end
    step();
    tests_run++; if (head !== 5'd2 || empty !== 1'b1 || count !== 6'd0) begin tests_failed++;
      $display("FAIL ooo_after: got h%0d e%b c%0d want h2 e1 c0", head, empty, count); end
  endtask

  task automatic test_wrap();
    logic [4:0] base;
    base = 5'd2;
    for (int i = 0; i < 14; i++) begin
      do_alloc(2'd2);
      do_issue(1'b1, base, 1'b1, base + 5'd1);
      do_done(1'b1, base, 1'b0, 1'b1, base + 5'd1, 1'b0);
      step();
      base = base + 5'd2;
    end
    tests_run++; if (head !== 5'd30 || tail !== 5'd30 || count !== 6'd0) begin tests_failed++;
      $display("FAIL wrap_setup: got h%0d t%0d c%0d want 30/30/0", head, tail, count); end
    do_alloc(2'd2);
    tests_run++; if (tail !== 5'd0) begin tests_failed++;
      $display("FAIL wrap_tail0: got %0d want 0", tail); end
    do_alloc(2'd2);
    tests_run++; if (tail !== 5'd2 || count !== 6'd4) begin tests_failed++;
      $display("FAIL wrap_tail2: got t%0d c%0d want t2 c4", tail, count); end
    do_issue(1'b1, 5'd30, 1'b1, 5'd31);
    do_done(1'b1, 5'd30, 1'b0, 1'b1, 5'd31, 1'b0);
    tests_run++; if (retire_count !== 2'd2) begin tests_failed++;
      $display("FAIL wrap_retire: got %0d want 2", retire_count); end
    // Allocate in the same cycle as the double retirement
    do_alloc(2'd1);
    tests_run++; if (head !== 5'd0 || tail !== 5'd3 || count !== 6'd3) begin tests_failed++;
      $display("FAIL wrap_simul: got h%0d t%0d c%0d want 0/3/3", head, tail, count); end
    tests_run++; if (pending !== 32'h7) begin tests_failed++;
      $display("FAIL wrap_pending: got %h want %h", pending, 32'h7); end
    do_flush();
    tests_run++; if (head !== 5'd0 || tail !== 5'd0 || count !== 6'd0 || pending !== 32'h0)
      begin tests_failed++;
      $display("FAIL wrap_flush: got h%0d t%0d c%0d p%h want zeros", head, tail, count, pending);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 15; i++) do_alloc(2'd2);
    tests_run++; if (count !== 6'd30 || alloc_avail !== 2'd2) begin tests_failed++;
      $display("FAIL full_30: got c%0d a%0d want c30 a2", count, alloc_avail); end
    do_alloc(2'd1);
    tests_run++; if (alloc_avail !== 2'd1) begin tests_failed++;
      $display("FAIL full_avail1: got %0d want 1", alloc_avail); end
    do_alloc(2'd1);
    tests_run++; if (full !== 1'b1 || alloc_avail !== 2'd0 || count !== 6'd32) begin
      tests_failed++;
      $display("FAIL full_32: got f%b a%0d c%0d want f1 a0 c32", full, alloc_avail, count);
    end
    // Oversized request must be dropped without any state change
    do_alloc(2'd1);
    tests_run++; if (count !== 6'd32 || tail !== 5'd0 || pending !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL full_ignored: got c%0d t%0d p%h want c32 t0 pffffffff", count, tail, pending);
    end
    do_flush();
    tests_run++; if (empty !== 1'b1) begin tests_failed++;
      $display("FAIL full_flush: got empty %b want 1", empty); end
  endtask

  task automatic test_fault();
    do_alloc(2'd2); do_alloc(2'd2); do_alloc(2'd2);
    do_issue(1'b1, 5'd0, 1'b1, 5'd1);
    do_issue(1'b1, 5'd2, 1'b1, 5'd3);
    do_issue(1'b1, 5'd4, 1'b1, 5'd5);
    do_done(1'b1, 5'd0, 1'b0, 1'b1, 5'd1, 1'b0);
    do_done(1'b1, 5'd2, 1'b0, 1'b1, 5'd3, 1'b0);
    tests_run++; if (head !== 5'd2) begin tests_failed++;
      $display("FAIL fault_head2: got %0d want 2", head); end
    do_done(1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0);
    step();
    tests_run++; if (head !== 5'd5 || retire_count !== 2'd0) begin tests_failed++;
      $display("FAIL fault_head5: got h%0d r%0d want h5 r0", head, retire_count); end
    do_done(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
    tests_run++; if (fault_valid !== 1'b1 || fault_addr !== 5'd5 || retire_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL fault_flag: got v%b a%0d r%0d want v1 a5 r0",
               fault_valid, fault_addr, retire_count);
    end
    step();
    tests_run++; if (retire_count !== 2'd0 || head !== 5'd5 || count !== 6'd1) begin
      tests_failed++;
      $display("FAIL fault_stall: got r%0d h%0d c%0d want r0 h5 c1", retire_count, head, count);
    end
    do_flush();
    tests_run++; if (count !== 6'd0 || head !== 5'd0 || fault_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fault_flush: got c%0d h%0d v%b want 0/0/0", count, head, fault_valid);
    end
  endtask

  task automatic test_flush_retire();
    do_alloc(2'd2);
    do_issue(1'b1, 5'd0, 1'b0, 5'd0);
    do_done(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    tests_run++; if (retire_count !== 2'd1) begin tests_failed++;
      $display("FAIL flushret_pre: got %0d want 1", retire_count); end
    flush = 1'b1;
    #1;
    tests_run++; if (retire_count !== 2'd0) begin tests_failed++;
      $display("FAIL flushret_gate: got %0d want 0", retire_count); end
    step();
    tests_run++; if (count !== 6'd0 || head !== 5'd0 || empty !== 1'b1) begin tests_failed++;
      $display("FAIL flushret_post: got c%0d h%0d e%b want 0/0/1", count, head, empty); end
  endtask

  task automatic test_stray();
    do_alloc(2'd2); do_alloc(2'd2);
    // Issue and done on entry 3 in the same cycle: the done is dropped
    issue_enable_0 = 1'b1; issue_addr_0 = 5'd3;
    done_enable_0  = 1'b1; done_addr_0  = 5'd3;
    step();
    tests_run++; if (pending !== 32'h7) begin tests_failed++;
      $display("FAIL stray_same_cycle: got %h want %h", pending, 32'h7); end
    do_issue(1'b1, 5'd0, 1'b1, 5'd1);
    do_issue(1'b1, 5'd2, 1'b0, 5'd0);
    do_done(1'b1, 5'd0, 1'b0, 1'b1, 5'd1, 1'b0);
    do_done(1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    step();
    tests_run++; if (head !== 5'd3 || retire_count !== 2'd0 || count !== 6'd1) begin
      tests_failed++;
      $display("FAIL stray_blocked: got h%0d r%0d c%0d want h3 r0 c1", head, retire_count, count);
    end
    do_done(1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0);
    do_issue(1'b1, 5'd9, 1'b0, 5'd0);
    tests_run++; if (pending !== 32'h0 || count !== 6'd1 || head !== 5'd3 ||
                     retire_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL stray_free9: got p%h c%0d h%0d r%0d want p0 c1 h3 r0",
               pending, count, head, retire_count);
    end
    do_done(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0);
    tests_run++; if (retire_count !== 2'd1) begin tests_failed++;
      $display("FAIL stray_done3: got %0d want 1", retire_count); end
    step();
    tests_run++; if (head !== 5'd4 || empty !== 1'b1) begin tests_failed++;
      $display("FAIL stray_final: got h%0d e%b want h4 e1", head, empty); end
  endtask

  task automatic test_reset_override();
    do_alloc(2'd2);
    reset = 1'b0; flush = 1'b1; alloc_count = 2'd2;
    issue_enable_0 = 1'b1; issue_addr_0 = 5'd4;
    step();
    tests_run++; if (count !== 6'd0 || head !== 5'd0 || tail !== 5'd0 || pending !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_override: got c%0d h%0d t%0d p%h want zeros", count, head, tail, pending);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_alloc_issue();
    test_out_of_order();
    test_wrap();
    test_full();
    test_fault();
    test_flush_retire();
    test_stray();
    test_reset_override();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
